// File: rtl/pspin_egress_pkg.sv
// Shared constants and FSM encoding for the PsPIN egress DMA.
// Status codes, beat geometry and the AXI 4 KiB page size live here.
package pspin_egress_pkg;

    localparam logic [1:0] STATUS_OK       = 2'd0;
    localparam logic [1:0] STATUS_AXI_ERR  = 2'd1;
    localparam logic [1:0] STATUS_BAD_DESC = 2'd2;

    localparam int unsigned BEAT_BYTES = 64;
    localparam int unsigned BEAT_SHIFT = 6;
    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned PAGE_SHIFT = 12;

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StData,
        StStatus
    } egress_state_e;

endpackage

// File: rtl/pspin_egress_burst_split.sv
// Splits a 64 B-aligned read into at most two INCR bursts so that no burst
// crosses a 4 KiB page; also reports the total beat count.
module pspin_egress_burst_split
    import pspin_egress_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned LenWidth  = 32
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [LenWidth-1:0]  len_i,
    output logic [LenWidth-1:0]  beats_o,
    output logic                 split_o,
    output logic [AddrWidth-1:0] addr0_o,
    output logic [7:0]           arlen0_o,
    output logic [AddrWidth-1:0] addr1_o,
    output logic [7:0]           arlen1_o
);

    logic [12:0]         room_bytes;
    logic [LenWidth-1:0] room_beats;
    logic [LenWidth-1:0] beats0;
    logic [LenWidth-1:0] beats1;

    always_comb begin
        beats_o    = (len_i + LenWidth'(BEAT_BYTES - 1)) >> BEAT_SHIFT;
        // Bytes left before the next page boundary (4096 when page-aligned).
        room_bytes = 13'(PAGE_BYTES) - {1'b0, addr_i[PAGE_SHIFT-1:0]};
        room_beats = LenWidth'(room_bytes >> BEAT_SHIFT);
        split_o    = beats_o > room_beats;
        beats0     = split_o ? room_beats : beats_o;
        beats1     = beats_o - beats0;
        addr0_o    = addr_i;
        addr1_o    = {addr_i[AddrWidth-1:PAGE_SHIFT] + (AddrWidth - PAGE_SHIFT)'(1),
                      {PAGE_SHIFT{1'b0}}};
        arlen0_o   = 8'(beats0 - LenWidth'(1));
        arlen1_o   = 8'(beats1 - LenWidth'(1));
    end

endmodule

// File: rtl/pspin_egress_dma.sv
// Egress DMA: reads a descriptor's payload from PsPIN memory over AXI and
// streams it to the NIC over AXI-Stream, then reports a status word.
module pspin_egress_dma
    import pspin_egress_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 512,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned LEN_WIDTH      = 32,
    parameter int unsigned TAG_WIDTH      = 32,
    parameter int unsigned EGRESS_DMA_MTU = 1500
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXI_ADDR_WIDTH-1:0]   read_desc_addr,
    input  logic [LEN_WIDTH-1:0]        read_desc_len,
    input  logic [TAG_WIDTH-1:0]        read_desc_tag,
    input  logic                        read_desc_valid,
    output logic                        read_desc_ready,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_pspin_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_pspin_araddr,
    output logic [7:0]                  m_axi_pspin_arlen,
    output logic [2:0]                  m_axi_pspin_arsize,
    output logic [1:0]                  m_axi_pspin_arburst,
    output logic                        m_axi_pspin_arlock,
    output logic [3:0]                  m_axi_pspin_arcache,
    output logic [2:0]                  m_axi_pspin_arprot,
    output logic                        m_axi_pspin_arvalid,
    input  logic                        m_axi_pspin_arready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_pspin_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_pspin_rdata,
    input  logic [1:0]                  m_axi_pspin_rresp,
    input  logic                        m_axi_pspin_rlast,
    input  logic                        m_axi_pspin_rvalid,
    output logic                        m_axi_pspin_rready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axis_nic_tx_tdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axis_nic_tx_tkeep,
    output logic                        m_axis_nic_tx_tvalid,
    input  logic                        m_axis_nic_tx_tready,
    output logic                        m_axis_nic_tx_tlast,
    output logic [0:0]                  m_axis_nic_tx_tuser,
    output logic [TAG_WIDTH-1:0]        status_tag,
    output logic [1:0]                  status_error,
    output logic                        status_valid,
    input  logic                        status_ready
);

    localparam int unsigned KEEP_W = AXI_DATA_WIDTH / 8;

    egress_state_e             state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [TAG_WIDTH-1:0]      tag_q, tag_d;
    logic                      second_q, second_d;
    logic [LEN_WIDTH-1:0]      beats_done_q, beats_done_d;
    logic                      err_q, err_d;
    logic [1:0]                status_q, status_d;

    logic [LEN_WIDTH-1:0]      beats;
    logic                      split;
    logic [AXI_ADDR_WIDTH-1:0] addr0, addr1;
    logic [7:0]                arlen0, arlen1;
    logic                      bad_desc;
    logic                      final_beat;
    logic [KEEP_W-1:0]         keep_last;
    logic                      unused_rid;

    assign unused_rid = ^m_axi_pspin_rid;

    pspin_egress_burst_split #(
        .AddrWidth (AXI_ADDR_WIDTH),
        .LenWidth  (LEN_WIDTH)
    ) u_burst_split (
        .addr_i   (addr_q),
        .len_i    (len_q),
        .beats_o  (beats),
        .split_o  (split),
        .addr0_o  (addr0),
        .arlen0_o (arlen0),
        .addr1_o  (addr1),
        .arlen1_o (arlen1)
    );

    assign bad_desc = (read_desc_len == '0)
                   || (read_desc_len > LEN_WIDTH'(EGRESS_DMA_MTU))
                   || (read_desc_addr[BEAT_SHIFT-1:0] != '0);

    // The beat counter, not rlast, marks the end so the split point never asserts tlast.
    assign final_beat = (beats_done_q == beats - LEN_WIDTH'(1));
    assign keep_last  = (len_q[BEAT_SHIFT-1:0] == '0) ? '1
                      : ~({KEEP_W{1'b1}} << len_q[BEAT_SHIFT-1:0]);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        tag_d        = tag_q;
        second_d     = second_q;
        beats_done_d = beats_done_q;
        err_d        = err_q;
        status_d     = status_q;

        read_desc_ready      = 1'b0;
        m_axi_pspin_arid     = '0;
        m_axi_pspin_araddr   = '0;
        m_axi_pspin_arlen    = '0;
        m_axi_pspin_arsize   = '0;
        m_axi_pspin_arburst  = '0;
        m_axi_pspin_arlock   = 1'b0;
        m_axi_pspin_arcache  = '0;
        m_axi_pspin_arprot   = '0;
        m_axi_pspin_arvalid  = 1'b0;
        m_axi_pspin_rready   = 1'b0;
        m_axis_nic_tx_tdata  = '0;
        m_axis_nic_tx_tkeep  = '0;
        m_axis_nic_tx_tvalid = 1'b0;
        m_axis_nic_tx_tlast  = 1'b0;
        m_axis_nic_tx_tuser  = '0;
        status_tag           = '0;
        status_error         = '0;
        status_valid         = 1'b0;

        // Outputs stay quiet for the whole reset cycle, even mid-transfer.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    read_desc_ready = 1'b1;
                    if (read_desc_valid) begin
                        addr_d       = read_desc_addr;
                        len_d        = read_desc_len;
                        tag_d        = read_desc_tag;
                        second_d     = 1'b0;
                        beats_done_d = '0;
                        err_d        = 1'b0;
                        if (bad_desc) begin
                            status_d = STATUS_BAD_DESC;
                            state_d  = StStatus;
                        end else begin
                            state_d  = StAr;
                        end
                    end
                end
                StAr: begin
                    m_axi_pspin_araddr  = second_q ? addr1 : addr0;
                    m_axi_pspin_arlen   = second_q ? arlen1 : arlen0;
                    m_axi_pspin_arsize  = 3'(BEAT_SHIFT);
                    m_axi_pspin_arburst = 2'b01;
                    m_axi_pspin_arvalid = 1'b1;
                    if (m_axi_pspin_arready) begin
                        state_d = StData;
                    end
                end
                StData: begin
                    m_axi_pspin_rready   = m_axis_nic_tx_tready;
                    m_axis_nic_tx_tvalid = m_axi_pspin_rvalid;
                    m_axis_nic_tx_tdata  = m_axi_pspin_rdata;
                    m_axis_nic_tx_tkeep  = final_beat ? keep_last : '1;
                    m_axis_nic_tx_tlast  = final_beat;
                    if (m_axi_pspin_rvalid && m_axis_nic_tx_tready) begin
                        beats_done_d = beats_done_q + LEN_WIDTH'(1);
                        err_d        = err_q | (m_axi_pspin_rresp != 2'b00);
                        if (final_beat) begin
                            status_d = err_d ? STATUS_AXI_ERR : STATUS_OK;
                            state_d  = StStatus;
                        end else if (m_axi_pspin_rlast && !second_q && split) begin
                            second_d = 1'b1;
                            state_d  = StAr;
                        end
                    end
                end
                StStatus: begin
                    status_valid = 1'b1;
                    status_tag   = tag_q;
                    status_error = status_q;
                    if (status_ready) begin
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            len_q        <= '0;
            tag_q        <= '0;
            second_q     <= 1'b0;
            beats_done_q <= '0;
            err_q        <= 1'b0;
            status_q     <= STATUS_OK;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            tag_q        <= tag_d;
            second_q     <= second_d;
            beats_done_q <= beats_done_d;
            err_q        <= err_d;
            status_q     <= status_d;
        end
    end

endmodule

// File: tb/tb_pspin_egress_dma.sv
// Bench for pspin_egress_dma: a small AXI read slave over a synthetic memory,
// a stream/status monitor, a descriptor table and a mid-transfer reset sequence.
module tb_pspin_egress_dma;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam logic [63:0] KEEP_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   desc_addr, desc_len, desc_tag;
    logic          desc_valid, desc_ready;
    logic [7:0]    arid;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic          arvalid, arready;
    logic [7:0]    rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tvalid, tready, tlast;
    logic [0:0]    tuser;
    logic [31:0]   st_tag_o;
    logic [1:0]    st_err_o;
    logic          st_valid, st_ready;

    always #5 clk = ~clk;

    pspin_egress_dma dut (
        .clk                  (clk),
        .rst                  (rst),
        .read_desc_addr       (desc_addr),
        .read_desc_len        (desc_len),
        .read_desc_tag        (desc_tag),
        .read_desc_valid      (desc_valid),
        .read_desc_ready      (desc_ready),
        .m_axi_pspin_arid     (arid),
        .m_axi_pspin_araddr   (araddr),
        .m_axi_pspin_arlen    (arlen),
        .m_axi_pspin_arsize   (arsize),
        .m_axi_pspin_arburst  (arburst),
        .m_axi_pspin_arlock   (arlock),
        .m_axi_pspin_arcache  (arcache),
        .m_axi_pspin_arprot   (arprot),
        .m_axi_pspin_arvalid  (arvalid),
        .m_axi_pspin_arready  (arready),
        .m_axi_pspin_rid      (rid),
        .m_axi_pspin_rdata    (rdata),
        .m_axi_pspin_rresp    (rresp),
        .m_axi_pspin_rlast    (rlast),
        .m_axi_pspin_rvalid   (rvalid),
        .m_axi_pspin_rready   (rready),
        .m_axis_nic_tx_tdata  (tdata),
        .m_axis_nic_tx_tkeep  (tkeep),
        .m_axis_nic_tx_tvalid (tvalid),
        .m_axis_nic_tx_tready (tready),
        .m_axis_nic_tx_tlast  (tlast),
        .m_axis_nic_tx_tuser  (tuser),
        .status_tag           (st_tag_o),
        .status_error         (st_err_o),
        .status_valid         (st_valid),
        .status_ready         (st_ready)
    );

    typedef struct {
        logic [31:0] addr, len, tag;
        logic        tog;
        int          err_beat;
        int          n_ar;
        logic [31:0] ar0_addr;
        int          ar0_len;
        logic [31:0] ar1_addr;
        int          ar1_len;
        int          n_beats;
        logic [63:0] last_keep;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[10];

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    // Stimulus state, applied 1 ns after each rising edge.
    logic        desc_pending = 1'b0;
    logic [31:0] d_addr = '0, d_len = '0, d_tag = '0;
    logic        rst_req = 1'b1;
    logic        tready_toggle = 1'b0;
    logic        stray = 1'b0;
    int          err_beat = -1;

    // AXI slave model.
    logic [31:0] sl_addr[$];
    int          sl_len[$];
    logic [31:0] cur_addr = '0;
    int          cur_left = 0;
    logic        hold = 1'b0;
    int          beat_idx = 0;
    logic        ar_seen = 1'b0, st_seen = 1'b0;
    logic [31:0] ar_pend_addr = '0;
    logic [7:0]  ar_pend_len = '0;

    // Monitor records.
    logic [31:0]   rec_ar_addr[$];
    int            rec_ar_len[$];
    logic [DW-1:0] b_data[$];
    logic [KW-1:0] b_keep[$];
    logic          b_last[$];
    int            ar_unstable = 0, ar_attr_bad = 0, rr_bad = 0, tuser_bad = 0;
    int unsigned   last_beat_cyc = 0, st_first_cyc = 0;
    logic          st_first_seen = 1'b0;
    int            st_count = 0;
    logic [31:0]   st_tag = '0;
    logic [1:0]    st_err = '0;

    function automatic logic [DW-1:0] mem_beat(input logic [31:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = a ^ (32'h9E37_79B9 * 32'(i + 1));
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst        = rst_req;
        desc_valid = desc_pending;
        desc_addr  = d_addr;
        desc_len   = d_len;
        desc_tag   = d_tag;
        arready    = ar_seen;
        st_ready   = st_seen;
        tready     = tready_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!hold && (cur_left > 0 || sl_addr.size() > 0)) begin
            if (cur_left == 0) begin
                cur_addr = sl_addr.pop_front();
                cur_left = sl_len.pop_front();
            end
            hold = 1'b1;
        end
        rvalid = hold | stray;
        rdata  = hold ? mem_beat(cur_addr) : '0;
        rlast  = hold && (cur_left == 1);
        rresp  = (hold && beat_idx == err_beat) ? 2'b10 : 2'b00;
        @(negedge clk);
        if (desc_valid && desc_ready) desc_pending = 1'b0;
        if (arvalid && arready) begin
            if (araddr !== ar_pend_addr || arlen !== ar_pend_len) ar_unstable++;
            if (arsize != 3'd6 || arburst != 2'b01 || arid != '0 || arlock
                || arcache != '0 || arprot != '0) ar_attr_bad++;
            rec_ar_addr.push_back(araddr);
            rec_ar_len.push_back(int'(arlen));
            sl_addr.push_back(araddr);
            sl_len.push_back(int'(arlen) + 1);
        end
        if (arvalid && !arready) begin
            ar_pend_addr = araddr;
            ar_pend_len  = arlen;
        end
        ar_seen = arvalid && !arready;
        if (tvalid && (rready !== tready)) rr_bad++;
        if (tvalid && tuser != '0) tuser_bad++;
        if (tvalid && tready) begin
            b_data.push_back(tdata);
            b_keep.push_back(tkeep);
            b_last.push_back(tlast);
            last_beat_cyc = cyc;
        end
        if (rvalid && rready && hold) begin
            hold     = 1'b0;
            cur_addr = cur_addr + 32'd64;
            cur_left--;
            beat_idx++;
        end
        if (st_valid && !st_first_seen) begin
            st_first_seen = 1'b1;
            st_first_cyc  = cyc;
        end
        if (st_valid && st_ready) begin
            st_count++;
            st_tag = st_tag_o;
            st_err = st_err_o;
        end
        st_seen = st_valid && !st_ready;
    endtask

    task automatic clear_records();
        rec_ar_addr.delete();
        rec_ar_len.delete();
        b_data.delete();
        b_keep.delete();
        b_last.delete();
        sl_addr.delete();
        sl_len.delete();
        cur_left = 0;
        hold = 1'b0;
        beat_idx = 0;
        ar_unstable = 0;
        ar_attr_bad = 0;
        rr_bad = 0;
        tuser_bad = 0;
        st_count = 0;
        st_first_seen = 1'b0;
    endtask

    task automatic run_desc(input logic [31:0] a, input logic [31:0] l, input logic [31:0] t,
                            input logic tog, input int eb);
        clear_records();
        d_addr = a;
        d_len = l;
        d_tag = t;
        tready_toggle = tog;
        err_beat = eb;
        desc_pending = 1'b1;
        for (int c = 0; c < 3000 && st_count == 0; c++) step();
        if (st_count == 0) check("status timeout", 64'd0, 64'd1);
        repeat (4) step();
    endtask

    initial begin
        logic [63:0] exp_keep;

        vecs[0] = '{32'h1c10_0000, 32'd64,   32'hA001, 1'b0, -1, 1, 32'h1c10_0000, 0,
                    32'h0, 0, 1, KEEP_ALL, 2'd0};
        vecs[1] = '{32'h1c10_0000, 32'd100,  32'hA002, 1'b0, -1, 1, 32'h1c10_0000, 1,
                    32'h0, 0, 2, 64'h0000_000F_FFFF_FFFF, 2'd0};
        vecs[2] = '{32'h1c10_0FC0, 32'd128,  32'hA003, 1'b0, -1, 2, 32'h1c10_0FC0, 0,
                    32'h1c10_1000, 0, 2, KEEP_ALL, 2'd0};
        vecs[3] = '{32'h1c20_0000, 32'd1500, 32'hA004, 1'b1, -1, 1, 32'h1c20_0000, 23,
                    32'h0, 0, 24, 64'h0000_0000_0FFF_FFFF, 2'd0};
        vecs[4] = '{32'h1c30_0000, 32'd192,  32'hA005, 1'b0, 0, 1, 32'h1c30_0000, 2,
                    32'h0, 0, 3, KEEP_ALL, 2'd1};
        vecs[5] = '{32'h1c10_0000, 32'd0,    32'hA006, 1'b0, -1, 0, 32'h0, 0,
                    32'h0, 0, 0, KEEP_ALL, 2'd2};
        vecs[6] = '{32'h1c10_0004, 32'd64,   32'hA007, 1'b0, -1, 0, 32'h0, 0,
                    32'h0, 0, 0, KEEP_ALL, 2'd2};
        vecs[7] = '{32'h1c10_0000, 32'd1501, 32'hA008, 1'b0, -1, 0, 32'h0, 0,
                    32'h0, 0, 0, KEEP_ALL, 2'd2};
        vecs[8] = '{32'h1c10_0C00, 32'd1500, 32'hA009, 1'b1, -1, 2, 32'h1c10_0C00, 15,
                    32'h1c10_1000, 7, 24, 64'h0000_0000_0FFF_FFFF, 2'd0};
        vecs[9] = '{32'h1c50_0000, 32'd1,    32'hA00A, 1'b0, -1, 1, 32'h1c50_0000, 0,
                    32'h0, 0, 1, 64'h1, 2'd0};

        rst = 1'b1; desc_valid = 1'b0; desc_addr = '0; desc_len = '0; desc_tag = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        tready = 1'b0; st_ready = 1'b0;

        repeat (3) step();
        check("rst desc_ready", 64'(desc_ready), 64'd0);
        check("rst arvalid", 64'(arvalid), 64'd0);
        check("rst tvalid", 64'(tvalid), 64'd0);
        check("rst rready", 64'(rready), 64'd0);
        check("rst status_valid", 64'(st_valid), 64'd0);
        rst_req = 1'b0;
        step();
        check("idle desc_ready", 64'(desc_ready), 64'd1);
        stray = 1'b1;
        step();
        check("stray rvalid rready", 64'(rready), 64'd0);
        check("stray rvalid tvalid", 64'(tvalid), 64'd0);
        stray = 1'b0;

        foreach (vecs[i]) begin
            run_desc(vecs[i].addr, vecs[i].len, vecs[i].tag, vecs[i].tog, vecs[i].err_beat);
            check($sformatf("v%0d ar count", i), 64'(rec_ar_addr.size()), 64'(vecs[i].n_ar));
            if (vecs[i].n_ar >= 1 && rec_ar_addr.size() >= 1) begin
                check($sformatf("v%0d ar0 addr", i), 64'(rec_ar_addr[0]), 64'(vecs[i].ar0_addr));
                check($sformatf("v%0d ar0 len", i), 64'(rec_ar_len[0]), 64'(vecs[i].ar0_len));
                check($sformatf("v%0d ar attrs", i), 64'(ar_attr_bad), 64'd0);
                check($sformatf("v%0d ar stable", i), 64'(ar_unstable), 64'd0);
            end
            if (vecs[i].n_ar == 2 && rec_ar_addr.size() == 2) begin
                check($sformatf("v%0d ar1 addr", i), 64'(rec_ar_addr[1]), 64'(vecs[i].ar1_addr));
                check($sformatf("v%0d ar1 len", i), 64'(rec_ar_len[1]), 64'(vecs[i].ar1_len));
            end
            check($sformatf("v%0d beat count", i), 64'(b_data.size()), 64'(vecs[i].n_beats));
            for (int k = 0; k < vecs[i].n_beats && k < b_data.size(); k++) begin
                exp_keep = (k == vecs[i].n_beats - 1) ? vecs[i].last_keep : KEEP_ALL;
                check($sformatf("v%0d beat%0d data", i, k),
                      64'(b_data[k] === mem_beat(vecs[i].addr + 32'(64 * k))), 64'd1);
                check($sformatf("v%0d beat%0d tkeep", i, k), b_keep[k], exp_keep);
                check($sformatf("v%0d beat%0d tlast", i, k), 64'(b_last[k]),
                      64'(k == vecs[i].n_beats - 1));
            end
            check($sformatf("v%0d rready tracks tready", i), 64'(rr_bad), 64'd0);
            check($sformatf("v%0d tuser", i), 64'(tuser_bad), 64'd0);
            check($sformatf("v%0d status count", i), 64'(st_count), 64'd1);
            check($sformatf("v%0d status tag", i), 64'(st_tag), 64'(vecs[i].tag));
            check($sformatf("v%0d status err", i), 64'(st_err), 64'(vecs[i].err));
            if (vecs[i].n_beats > 0)
                check($sformatf("v%0d status latency", i), 64'(st_first_cyc),
                      64'(last_beat_cyc + 1));
        end

        // Reset while the fifth beat of a 24-beat transfer is on the bus.
        clear_records();
        d_addr = 32'h1c40_0000; d_len = 32'd1500; d_tag = 32'hB001;
        tready_toggle = 1'b0; err_beat = -1; desc_pending = 1'b1;
        for (int c = 0; c < 200 && b_data.size() < 4; c++) step();
        check("pre-rst beats", 64'(b_data.size()), 64'd4);
        rst_req = 1'b1;
        step();
        check("mid-rst tvalid", 64'(tvalid), 64'd0);
        check("mid-rst rready", 64'(rready), 64'd0);
        check("mid-rst arvalid", 64'(arvalid), 64'd0);
        check("mid-rst desc_ready", 64'(desc_ready), 64'd0);
        check("mid-rst status_valid", 64'(st_valid), 64'd0);
        sl_addr.delete(); sl_len.delete(); cur_left = 0; hold = 1'b0;
        rst_req = 1'b0;
        step();
        check("post-rst idle", 64'(desc_ready), 64'd1);
        check("post-rst tvalid", 64'(tvalid), 64'd0);
        check("post-rst arvalid", 64'(arvalid), 64'd0);
        check("post-rst status_valid", 64'(st_valid), 64'd0);
        check("post-rst beats", 64'(b_data.size()), 64'd4);
        check("post-rst no status", 64'(st_count), 64'd0);

        run_desc(32'h1c60_0000, 32'd64, 32'hB002, 1'b0, -1);
        check("after-rst beats", 64'(b_data.size()), 64'd1);
        check("after-rst tlast", 64'((b_data.size() == 1) && b_last[0]), 64'd1);
        check("after-rst status count", 64'(st_count), 64'd1);
        check("after-rst status tag", 64'(st_tag), 64'h0000_B002);
        check("after-rst status err", 64'(st_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
